// File: rtl/onehot_dec_stream_v_pkg.sv
// onehot_dec_pkg: shared definitions for the streaming one-hot decoder.
//   - state encoding for the skid buffer FSM
//   - f_onehot: binary code -> {err, onehot} over a fixed maximum width
//   - f_cnt_max: all-ones value for a saturating counter of a given width
package onehot_dec_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  typedef enum logic [1:0] {
    S_EMPTY = ST_EMPTY,
    S_ONE   = ST_ONE,
    S_FULL  = ST_FULL
  } state_t;

  // Widest one-hot word the decode function can produce; callers slice it.
  localparam int MAX_W = 64;

  // Bit MAX_W is the error flag; bits [MAX_W-1:0] hold the one-hot word,
  // which stays all-zero when the code is out of range.
  function automatic logic [MAX_W:0] f_onehot(input int unsigned code,
                                              input int unsigned out_w);
    logic [MAX_W:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      r[i] = (code == i) && (code < out_w);
    end
    r[MAX_W] = (code >= out_w);
    return r;
  endfunction

  function automatic logic [63:0] f_cnt_max(input int unsigned w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/onehot_dec_stream_v_if.sv
// onehot_dec_stream_v_if: handshake bundle of the streaming one-hot decoder.
//   slave  : decoder view (consumes code stream, produces one-hot stream)
//   master : producer/consumer view driving the decoder
// Signals: i_code/i_valid/o_ready (input stream), o_onehot/o_code_err/o_valid/
//          i_ready (output stream), i_clr_count/o_count (good-beat counter).
interface onehot_dec_stream_v_if #(
  parameter int CODE_W = 2,
  parameter int OUT_W  = 4,
  parameter int CNT_W  = 8
);
  logic [CODE_W-1:0] i_code;
  logic              i_valid;
  logic              o_ready;
  logic [OUT_W-1:0]  o_onehot;
  logic              o_code_err;
  logic              o_valid;
  logic              i_ready;
  logic              i_clr_count;
  logic [CNT_W-1:0]  o_count;

  modport slave (
    input  i_code, i_valid, i_ready, i_clr_count,
    output o_ready, o_onehot, o_code_err, o_valid, o_count
  );

  modport master (
    output i_code, i_valid, i_ready, i_clr_count,
    input  o_ready, o_onehot, o_code_err, o_valid, o_count
  );
endinterface

// File: rtl/onehot_dec_stream_v_skid_buf.sv
// skid_buf_v: two-entry registered skid buffer.
//   clk, rst              clock, async active-high reset
//   in_data/in_valid      upstream beat
//   in_ready              registered: low only while both entries are held
//   out_data/out_valid    registered output stage; out_data is zero when empty
//   out_ready             downstream accept
//
// state   | meaning
// EMPTY   | no beat held, output invalid
// ONE     | one beat in the output register
// FULL    | output register and skid register both hold beats
module skid_buf_v
  import onehot_dec_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  state_t       state;
  logic [W-1:0] out_q;
  logic [W-1:0] skid_q;
  logic         out_valid_q;
  logic         in_ready_q;
  logic         in_xfer;
  logic         out_xfer;

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid_q & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_EMPTY;
      out_q       <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state)
        S_EMPTY: begin
          if (in_xfer) begin
            out_q       <= in_data;
            out_valid_q <= 1'b1;
            state       <= S_ONE;
          end
        end
        S_ONE: begin
          if (in_xfer && out_xfer) begin
            out_q <= in_data;
          end else if (in_xfer) begin
            skid_q     <= in_data;
            in_ready_q <= 1'b0;
            state      <= S_FULL;
          end else if (out_xfer) begin
            // Clear the payload so the output reads zero while invalid.
            out_q       <= '0;
            out_valid_q <= 1'b0;
            state       <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (out_xfer) begin
            out_q      <= skid_q;
            in_ready_q <= 1'b1;
            state      <= S_ONE;
          end
        end
        default: begin
          state       <= S_EMPTY;
          out_q       <= '0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: rtl/onehot_dec_stream_v.sv
// onehot_dec_stream_v: streaming binary-to-one-hot decoder.
//   i_clk, i_rst  clock, async active-high reset
//   bus (slave)   i_code/i_valid/o_ready in, o_onehot/o_code_err/o_valid/i_ready
//                 out, i_clr_count/o_count saturating good-beat counter
// Codes are decoded before the skid buffer, so only {err, onehot} is stored.
module onehot_dec_stream_v
  import onehot_dec_pkg::*;
#(
  parameter int CODE_W = 2,
  parameter int OUT_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  onehot_dec_stream_v_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(f_cnt_max(CNT_W));

  logic [MAX_W:0] dec_full;
  logic           unused_dec;
  logic [OUT_W:0] in_payload;
  logic [OUT_W:0] out_payload;
  logic [CNT_W-1:0] cnt_q;

  assign dec_full   = f_onehot(32'(bus.i_code), OUT_W);
  assign unused_dec = ^dec_full;
  assign in_payload = {dec_full[MAX_W], dec_full[OUT_W-1:0]};

  skid_buf_v #(.W(OUT_W + 1)) u_skid (
    .clk       (i_clk),
    .rst       (i_rst),
    .in_data   (in_payload),
    .in_valid  (bus.i_valid),
    .in_ready  (bus.o_ready),
    .out_data  (out_payload),
    .out_valid (bus.o_valid),
    .out_ready (bus.i_ready)
  );

  assign bus.o_onehot   = out_payload[OUT_W-1:0];
  assign bus.o_code_err = out_payload[OUT_W];

  // Clear wins over a same-cycle increment; saturate instead of wrapping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (bus.i_clr_count) begin
      cnt_q <= '0;
    end else if (bus.o_valid && bus.i_ready && !bus.o_code_err && cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.o_count = cnt_q;

endmodule
